// File: rtl/fec_frame_sequencer.sv
// Frame sequencer: pulls FRAME_WORDS buffer words and steps each through encoder then modulator.
// Define FEC_SEQ_TIMEOUT_EN to add a per-wait-state watchdog that aborts a stuck frame.
module fec_frame_sequencer #(
    parameter int FRAME_WORDS    = 8,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int FCNT_W         = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic                           req,
    output logic                           ack,
    input  logic                           buff_empty,
    input  logic                           buff_rd_valid,
    output logic                           rd_en_buff,
    output logic                           req_encoder,
    input  logic                           ack_encoder,
    output logic                           en_encoder,
    output logic                           req_modulator,
    input  logic                           ack_modulator,
    output logic                           en_modulator,
    output logic                           busy,
    output logic [$clog2(FRAME_WORDS)-1:0] word_idx,
    output logic [FCNT_W-1:0]              frame_cnt,
    output logic                           err
);
    localparam int IDX_W = $clog2(FRAME_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_ENC   = 3'd3;
    localparam logic [2:0] S_MOD   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ABORT = 3'd6;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       timeout;

`ifdef FEC_SEQ_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TCNT_W-1:0] tcnt;
    logic              waiting;

    assign waiting = (state == S_WAIT) || (state == S_ENC) || (state == S_MOD);
    // tcnt holds the number of cycles already spent in the current wait state.
    assign timeout = waiting && (tcnt == TCNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt <= '0;
        end else if (state_nxt != state) begin
            tcnt <= '0;
        end else if (waiting) begin
            tcnt <= tcnt + TCNT_W'(1);
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout = 1'b0;
`endif

    // Stage handshake: req_* is held high from state entry until the matching
    // ack_* is sampled high on a rising edge (first cycle counts); req_* drops
    // the following cycle. An ack_* seen while its req_* is low has no effect.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (req && en) state_nxt = S_FETCH;
            S_FETCH: if (en && !buff_empty) state_nxt = S_WAIT;
            S_WAIT: begin
                if (buff_rd_valid) state_nxt = S_ENC;
                else if (timeout)  state_nxt = S_ABORT;
            end
            S_ENC: begin
                if (ack_encoder)  state_nxt = S_MOD;
                else if (timeout) state_nxt = S_ABORT;
            end
            S_MOD: begin
                if (ack_modulator) state_nxt = (word_idx == LAST_IDX) ? S_DONE : S_FETCH;
                else if (timeout)  state_nxt = S_ABORT;
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ABORT: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            word_idx  <= '0;
            frame_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && req && en) begin
                word_idx <= '0;
            end else if (state == S_MOD && ack_modulator && word_idx != LAST_IDX) begin
                word_idx <= word_idx + IDX_W'(1);
            end
            if (state == S_DONE) begin
                frame_cnt <= frame_cnt + FCNT_W'(1);
            end
        end
    end

    // Outputs decode state directly so an async reset clears them at once.
    assign busy          = (state != S_IDLE);
    assign rd_en_buff    = (state == S_FETCH) && en && !buff_empty;
    assign req_encoder   = (state == S_ENC);
    assign req_modulator = (state == S_MOD);
    assign en_encoder    = (state == S_FETCH) || (state == S_WAIT) || (state == S_ENC);
    assign en_modulator  = (state == S_ENC) || (state == S_MOD);
    assign ack           = (state == S_DONE);
    assign err           = (state == S_ABORT);

endmodule

// File: tb/tb_fec_frame_sequencer.sv
// Bench for fec_frame_sequencer: directed and randomized frames against a per-word delay model.
// Also builds with FEC_SEQ_TIMEOUT_EN to exercise the watchdog abort.
module tb_fec_frame_sequencer;
    localparam int FW     = 8;
    localparam int TMO    = 16;
    localparam int FCNT_W = 16;
    localparam int IDX_W  = $clog2(FW);
    localparam int P_FETCH = 0, P_DATA = 1, P_ENC = 2, P_MOD = 3, P_DONE = 4;
`ifdef FEC_SEQ_TIMEOUT_EN
    localparam int HOLD_LIMIT = TMO;
`else
    localparam int HOLD_LIMIT = 300;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0, req = 1'b0, buff_empty = 1'b1, buff_rd_valid = 1'b0;
    logic ack_encoder = 1'b0, ack_modulator = 1'b0;
    logic ack, rd_en_buff, req_encoder, en_encoder, req_modulator, en_modulator, busy, err;
    logic [IDX_W-1:0]  word_idx;
    logic [FCNT_W-1:0] frame_cnt;

    int tests = 0;
    int fails = 0;
    // Per-word environment delays: empty stall, data latency, encoder/modulator ack delay, en-low gap.
    int stall[FW], dd[FW], ed[FW], md[FW], eg[FW];
    logic [FCNT_W-1:0] exp_cnt = '0;
    logic [IDX_W-1:0]  exp_q[$];

    always #5 clk = ~clk;

    fec_frame_sequencer #(.FRAME_WORDS(FW), .TIMEOUT_CYCLES(TMO), .FCNT_W(FCNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .ack(ack),
        .buff_empty(buff_empty), .buff_rd_valid(buff_rd_valid), .rd_en_buff(rd_en_buff),
        .req_encoder(req_encoder), .ack_encoder(ack_encoder), .en_encoder(en_encoder),
        .req_modulator(req_modulator), .ack_modulator(ack_modulator), .en_modulator(en_modulator),
        .busy(busy), .word_idx(word_idx), .frame_cnt(frame_cnt), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_plan();
        for (int i = 0; i < FW; i++) begin
            stall[i] = 0; dd[i] = 0; ed[i] = 0; md[i] = 0; eg[i] = 0;
        end
    endtask

    task automatic random_plan();
        for (int i = 0; i < FW; i++) begin
            stall[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            dd[i]    = $urandom_range(0, 2);
            ed[i]    = $urandom_range(0, 3);
            md[i]    = $urandom_range(0, 3);
            eg[i]    = (i < FW - 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
        end
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req = 1'b0;
            chk("idle_busy", busy, 0);
            chk("idle_ack", ack, 0);
        end
        chk("frame_cnt", frame_cnt, exp_cnt);
        chk("idle_err", err, 0);
    endtask

    // Plays buffer, encoder and modulator for one frame, following the delay plan.
    task automatic run_frame(input int hold_word, input int rst_word);
        int phase, w, reads, bcyc, exp_bcyc;
        int empty_left, data_left, enc_left, mod_left, gap_left, held;
        bit done, mod_first;
        logic [IDX_W-1:0] front;
        w = 0; reads = 0; bcyc = 0; gap_left = 0; held = 0; done = 0; mod_first = 0;
        data_left = 0; enc_left = 0; mod_left = 0;
        exp_q.delete();
        exp_bcyc = 1;
        for (int i = 0; i < FW; i++)
            exp_bcyc += 4 + stall[i] + dd[i] + ed[i] + md[i] + ((eg[i] > md[i] + 1) ? eg[i] - md[i] - 1 : 0);
        @(negedge clk);
        req = 1'b1; en = 1'b1; buff_empty = 1'b0; buff_rd_valid = 1'b0;
        ack_encoder = 1'b0; ack_modulator = 1'b0;
        phase = P_FETCH; empty_left = stall[0];
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            @(negedge clk);
            if (busy) bcyc++;
            if (cyc == 0) chk("start_busy", busy, 1);
            req = (phase == P_DONE) ? 1'b0 : 1'($urandom_range(0, 1));
            buff_rd_valid = 1'b0;
            ack_encoder   = 1'($urandom_range(0, 1));
            ack_modulator = 1'($urandom_range(0, 1));
            if (phase == P_MOD && mod_first && eg[w] > 0) gap_left = eg[w];
            mod_first = 0;
            en = (gap_left == 0);
            if (gap_left > 0) gap_left--;
            case (phase)
                P_FETCH: begin
                    buff_empty = en && (empty_left > 0);
                    if (en && empty_left > 0) empty_left--;
                    #1;
                    chk("rd_en_buff", rd_en_buff, en && !buff_empty);
                    if (en && !buff_empty) begin
                        reads++;
                        exp_q.push_back(IDX_W'(w));
                        phase = P_DATA;
                        data_left = dd[w];
                    end
                end
                P_DATA: begin
                    chk("wait_en_encoder", en_encoder, 1);
                    if (data_left == 0) begin
                        buff_rd_valid = 1'b1;
                        phase = P_ENC;
                        enc_left = ed[w];
                    end else begin
                        data_left--;
                    end
                end
                P_ENC: begin
                    chk("req_encoder_hold", req_encoder, 1);
                    chk("enc_word_idx", word_idx, w);
                    chk("enc_en_modulator", en_modulator, 1);
                    if (w == rst_word) begin
                        #2 rst_n = 1'b0;
                        #1;
                        chk("rst_req_encoder", req_encoder, 0);
                        chk("rst_busy", busy, 0);
                        chk("rst_word_idx", word_idx, 0);
                        chk("rst_frame_cnt", frame_cnt, 0);
                        exp_cnt = '0;
                        req = 1'b0; ack_encoder = 1'b0; ack_modulator = 1'b0;
                        done = 1;
                    end else if (enc_left == 0) begin
                        ack_encoder = 1'b1;
                        phase = P_MOD;
                        mod_left = md[w];
                        mod_first = 1;
                    end else begin
                        ack_encoder = 1'b0;
                        enc_left--;
                    end
                end
                P_MOD: begin
                    if (w == hold_word && held == HOLD_LIMIT) begin
`ifdef FEC_SEQ_TIMEOUT_EN
                        chk("abort_err", err, 1);
                        chk("abort_req_modulator", req_modulator, 0);
                        chk("abort_no_ack", ack, 0);
`else
                        chk("hold_req_modulator", req_modulator, 1);
                        chk("hold_no_err", err, 0);
`endif
                        ack_modulator = 1'b0;
                        done = 1;
                    end else begin
                        chk("req_encoder_fall", req_encoder, 0);
                        chk("req_modulator_hold", req_modulator, 1);
                        chk("mod_word_idx", word_idx, w);
                        if (w == hold_word) begin
                            ack_modulator = 1'b0;
                            held++;
                        end else if (mod_left == 0) begin
                            ack_modulator = 1'b1;
                            front = exp_q.pop_front();
                            chk("sb_word", word_idx, front);
                            w++;
                            if (w == FW) begin
                                phase = P_DONE;
                            end else begin
                                phase = P_FETCH;
                                empty_left = stall[w];
                            end
                        end else begin
                            ack_modulator = 1'b0;
                            mod_left--;
                        end
                    end
                end
                default: begin
                    chk("done_ack", ack, 1);
                    chk("done_err", err, 0);
                    chk("frame_reads", reads, FW);
                    chk("frame_busy_cycles", bcyc, exp_bcyc);
                    exp_cnt = exp_cnt + 1'b1;
                    done = 1;
                end
            endcase
        end
        chk("frame_bounded", done, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ack", ack, 0);
        chk("reset_rd_en_buff", rd_en_buff, 0);
        chk("reset_req_encoder", req_encoder, 0);
        chk("reset_en_encoder", en_encoder, 0);
        chk("reset_req_modulator", req_modulator, 0);
        chk("reset_en_modulator", en_modulator, 0);
        chk("reset_busy", busy, 0);
        chk("reset_word_idx", word_idx, 0);
        chk("reset_frame_cnt", frame_cnt, 0);
        chk("reset_err", err, 0);
        rst_n = 1'b1;
        idle_check(2);

        clear_plan();                       // minimum-latency frame
        run_frame(-1, -1);
        idle_check(3);

        clear_plan(); ed[3] = 5;            // slow encoder on word 3
        run_frame(-1, -1);
        idle_check(3);

        clear_plan(); stall[4] = 10;        // buffer runs empty mid-frame
        run_frame(-1, -1);
        idle_check(3);

        clear_plan(); md[2] = 1; eg[2] = 6; // en drops during MOD_REQ of word 2
        run_frame(-1, -1);
        idle_check(3);

        for (int f = 0; f < 6; f++) begin
            random_plan();
            run_frame(-1, -1);
            idle_check(2);
        end

        clear_plan();                       // modulator never acks word 5
        run_frame(5, -1);
`ifdef FEC_SEQ_TIMEOUT_EN
        idle_check(3);
`else
        #2 rst_n = 1'b0;
        #1 chk("hold_rst_req_modulator", req_modulator, 0);
        exp_cnt = '0;
        @(negedge clk) rst_n = 1'b1;
        idle_check(2);
`endif

        clear_plan(); ed[1] = 10;           // reset during ENC_REQ of word 1
        run_frame(-1, 1);
        @(negedge clk) rst_n = 1'b1;
        idle_check(2);
        clear_plan();
        run_frame(-1, -1);
        idle_check(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
